// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with turnaround cycle and optional tenure limit
module bus_arbiter #(
  parameter int MASTER_QTY = 2,
  parameter int MAX_HOLD   = 0,
  parameter int MSEL_W     = (MASTER_QTY > 1) ? $clog2(MASTER_QTY) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_QTY-1:0] req,
  input  logic                  busy,
  output logic [MASTER_QTY-1:0] gnt,
  output logic [MSEL_W-1:0]     msel,
  output logic                  gnt_valid,
  output logic [15:0]           hold_cnt
);

  typedef enum logic [1:0] {IDLE, SWITCH, OWNED} state_t;

  state_t                  state, state_n;
  logic [MASTER_QTY-1:0]   gnt_n;
  logic [MSEL_W-1:0]       msel_n;
  logic [MSEL_W-1:0]       last_owner, last_owner_n;
  logic [15:0]             hold_n;
  logic [MASTER_QTY-1:0]   own_mask;
  logic [MASTER_QTY-1:0]   others;
  logic                    own_req;
  logic                    hold_limit;

  // First high bit of r searching upward from from+1, wrapping; the
  // starting master itself is considered last.
  function automatic logic [MSEL_W-1:0] rr_pick(input logic [MASTER_QTY-1:0] r,
                                                input logic [MSEL_W-1:0] from);
    logic [MSEL_W-1:0]     pick;
    logic [MASTER_QTY-1:0] sh;
    logic                  found;
    int                    idx;
    pick  = from;
    found = 1'b0;
    for (int i = 1; i <= MASTER_QTY; i++) begin
      idx = int'(from) + i;
      if (idx >= MASTER_QTY) idx = idx - MASTER_QTY;
      sh = r >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        pick  = MSEL_W'(idx);
      end
    end
    return pick;
  endfunction

  // msel doubles as the owner index while in SWITCH/OWNED.
  always_comb begin
    own_mask   = MASTER_QTY'(1) << msel;
    own_req    = |(req & own_mask);
    others     = req & ~own_mask;
    hold_limit = (MAX_HOLD != 0) && (hold_cnt >= 16'(MAX_HOLD));
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_n      = state;
    gnt_n        = gnt;
    msel_n       = msel;
    hold_n       = hold_cnt;
    last_owner_n = last_owner;
    case (state)
      IDLE: begin
        gnt_n  = '0;
        hold_n = '0;
        if (|req) begin
          msel_n  = rr_pick(req, last_owner);
          state_n = SWITCH;
        end
      end
      SWITCH: begin
        gnt_n        = own_mask;
        hold_n       = '0;
        last_owner_n = msel;
        state_n      = OWNED;
      end
      OWNED: begin
        last_owner_n = msel;
        if (!busy && (!own_req || hold_limit) && (|others)) begin
          msel_n  = rr_pick(others, msel);
          gnt_n   = '0;
          hold_n  = '0;
          state_n = SWITCH;
        end else if (!busy && !own_req) begin
          gnt_n   = '0;
          hold_n  = '0;
          state_n = IDLE;
        end else if (hold_cnt != 16'hFFFF) begin
          hold_n = hold_cnt + 16'd1;
        end
      end
      default: begin
        gnt_n   = '0;
        hold_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_valid  <= 1'b0;
      msel       <= '0;
      hold_cnt   <= '0;
      last_owner <= MSEL_W'(MASTER_QTY - 1);
    end else begin
      state      <= state_n;
      gnt        <= gnt_n;
      gnt_valid  <= |gnt_n;
      msel       <= msel_n;
      hold_cnt   <= hold_n;
      last_owner <= last_owner_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst;

  logic [1:0]  req2, gnt2;
  logic        busy2, msel2, gv2;
  logic [15:0] hold2;

  logic [3:0]  req4, gnt4;
  logic        busy4, gv4;
  logic [1:0]  msel4;
  logic [15:0] hold4;

  logic [1:0]  reqm, gntm;
  logic        busym, mselm, gvm;
  logic [15:0] holdm;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] pg2 = '0, pg4 = '0, pgm = '0;
  logic       pb2 = 1'b0, pb4 = 1'b0, pbm = 1'b0, prst = 1'b1;

  int         run, ngr, gap;
  logic [3:0] prev_g;
  logic [3:0] exp_order [5];

  always #5 clk = ~clk;

  bus_arbiter #(.MASTER_QTY(2), .MAX_HOLD(0)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .busy(busy2),
    .gnt(gnt2), .msel(msel2), .gnt_valid(gv2), .hold_cnt(hold2));

  bus_arbiter #(.MASTER_QTY(4), .MAX_HOLD(0)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .busy(busy4),
    .gnt(gnt4), .msel(msel4), .gnt_valid(gv4), .hold_cnt(hold4));

  bus_arbiter #(.MASTER_QTY(2), .MAX_HOLD(8)) u_dutm (
    .clk(clk), .rst(rst), .req(reqm), .busy(busym),
    .gnt(gntm), .msel(mselm), .gnt_valid(gvm), .hold_cnt(holdm));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic inv(input string tag, input logic [3:0] g, input logic gv,
                     input logic [31:0] ms, input logic [31:0] qty,
                     input logic [3:0] gp, input logic bp, input logic rp);
    check({tag, "_onehot"}, 32'($onehot0(g)), 32'd1);
    check({tag, "_valid"}, 32'(gv), 32'(|g));
    check({tag, "_msel_range"}, 32'(ms < qty), 32'd1);
    if (bp && gp != 4'd0 && !rp) check({tag, "_busy_hold"}, 32'(g), 32'(gp));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Invariants sampled mid-cycle on every DUT.
  always @(negedge clk) begin
    if (!rst) begin
      inv("dut2", {2'b00, gnt2}, gv2, 32'(msel2), 32'd2, pg2, pb2, prst);
      inv("dut4", gnt4, gv4, 32'(msel4), 32'd4, pg4, pb4, prst);
      inv("dutm", {2'b00, gntm}, gvm, 32'(mselm), 32'd2, pgm, pbm, prst);
    end
    pg2  <= {2'b00, gnt2};
    pg4  <= gnt4;
    pgm  <= {2'b00, gntm};
    pb2  <= busy2;
    pb4  <= busy4;
    pbm  <= busym;
    prst <= rst;
  end

  initial begin
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1;
    req2 = '0; busy2 = 1'b0;
    req4 = '0; busy4 = 1'b0;
    reqm = '0; busym = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt2", 32'(gnt2), 32'd0);
    check("rst_msel2", 32'(msel2), 32'd0);
    check("rst_gv2", 32'(gv2), 32'd0);
    check("rst_hold2", 32'(hold2), 32'd0);
    check("rst_gnt4", 32'(gnt4), 32'd0);
    check("rst_msel4", 32'(msel4), 32'd0);
    check("rst_gntm", 32'(gntm), 32'd0);
    rst = 1'b0;

    // Two-cycle request-to-grant latency, master 0 first after reset
    req2 = 2'b11;
    step;
    check("a_switch_gnt", 32'(gnt2), 32'd0);
    check("a_switch_msel", 32'(msel2), 32'd0);
    step;
    check("a_own_gnt", 32'(gnt2), 32'd1);
    check("a_own_msel", 32'(msel2), 32'd0);
    check("a_own_gv", 32'(gv2), 32'd1);
    check("a_own_hold0", 32'(hold2), 32'd0);
    step;
    check("a_own_hold1", 32'(hold2), 32'd1);

    // Owner drops req while busy: grant held until busy falls
    req2 = 2'b10;
    busy2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("a_busy_gnt", 32'(gnt2), 32'd1);
    end
    busy2 = 1'b0;
    step;
    check("a_dead_gnt", 32'(gnt2), 32'd0);
    check("a_dead_msel", 32'(msel2), 32'd1);
    step;
    check("a_new_gnt", 32'(gnt2), 32'd2);
    check("a_new_msel", 32'(msel2), 32'd1);
    check("a_new_hold", 32'(hold2), 32'd0);

    // Reset mid-tenure with busy high
    busy2 = 1'b1;
    step;
    check("a_pre_rst_gnt", 32'(gnt2), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("r_gnt2", 32'(gnt2), 32'd0);
    check("r_msel2", 32'(msel2), 32'd0);
    check("r_gv2", 32'(gv2), 32'd0);
    check("r_hold2", 32'(hold2), 32'd0);
    #5;
    busy2 = 1'b0;
    req2 = 2'b10;
    rst = 1'b0;
    step;
    check("r_switch_gnt", 32'(gnt2), 32'd0);
    check("r_switch_msel", 32'(msel2), 32'd1);
    step;
    check("r_own_gnt", 32'(gnt2), 32'd2);
    check("r_own_msel", 32'(msel2), 32'd1);

    // Release to IDLE keeps msel; next simultaneous request goes round-robin
    req2 = 2'b00;
    step;
    check("i_idle_gnt", 32'(gnt2), 32'd0);
    check("i_idle_msel", 32'(msel2), 32'd1);
    req2 = 2'b11;
    step;
    check("i_rr_msel", 32'(msel2), 32'd0);
    step;
    check("i_rr_gnt", 32'(gnt2), 32'd1);
    req2 = 2'b00;
    step;

    // Four masters, each owner releases after 5 cycles
    run = 0; ngr = 0; gap = 0; prev_g = '0;
    req4 = 4'b1111;
    for (int cyc = 0; cyc < 80 && ngr < 5; cyc++) begin
      step;
      if (gnt4 != 4'd0) begin
        if (gnt4 != prev_g) begin
          if (ngr > 0) check("b_gap", 32'(gap), 32'd1);
          check("b_order", 32'(gnt4), 32'(exp_order[ngr]));
          ngr++;
          run = 0;
        end
        check("b_hold", 32'(hold4), 32'(run));
        check("b_msel", 32'(4'b0001 << msel4), 32'(gnt4));
        run++;
        gap = 0;
        req4 = (run == 5) ? (4'b1111 & ~gnt4) : 4'b1111;
      end else begin
        gap++;
        req4 = 4'b1111;
      end
      prev_g = gnt4;
    end
    check("b_grant_count", 32'(ngr), 32'd5);
    req4 = '0;
    step;

    // Tenure limit of 8 cycles forces handover and back again
    reqm = 2'b01;
    step;
    check("c_switch_gnt", 32'(gntm), 32'd0);
    step;
    for (int k = 0; k <= 8; k++) begin
      check("c_gnt0", 32'(gntm), 32'd1);
      check("c_hold0", 32'(holdm), 32'(k));
      if (k == 2) reqm = 2'b11;
      step;
    end
    check("c_dead_gnt", 32'(gntm), 32'd0);
    check("c_dead_msel", 32'(mselm), 32'd1);
    step;
    for (int k = 0; k <= 8; k++) begin
      check("c_gnt1", 32'(gntm), 32'd2);
      check("c_hold1", 32'(holdm), 32'(k));
      step;
    end
    check("c_back_dead", 32'(gntm), 32'd0);
    check("c_back_msel", 32'(mselm), 32'd0);
    step;
    check("c_back_gnt", 32'(gntm), 32'd1);
    reqm = 2'b00;
    repeat (3) step;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MASTER_QTY, default 2: number of bus masters; SHALL be >= 1.
REQ-002 Parameter MAX_HOLD, default 0: maximum owner tenure in cycles while others wait; 0 disables the limit.
REQ-003 Parameter MSEL_W, default max($clog2(MASTER_QTY),1): msel width, matching the system mux select port.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  MASTER_QTY  per-master bus request (BUSRQ-style, active-high), held for the whole tenure.
REQ-007 busy  input  1  selected master has a bus cycle in flight (MREQ/IORQ active); ownership SHALL NOT change while high.
REQ-008 gnt  output  MASTER_QTY  one-hot grant (BUSACK-style) to the owning master, else all zero.
REQ-009 msel  output  MSEL_W  master select driven to the system bus mux.
REQ-010 gnt_valid  output  1  high exactly when some gnt bit is high.
REQ-011 hold_cnt  output  16  cycles the current owner has held the bus, saturating at 16'hFFFF.

Function
REQ-012 The block SHALL be a Moore FSM with states IDLE, SWITCH and OWNED; all outputs SHALL be registered.
REQ-013 IDLE: gnt=0; msel SHALL hold its last value; if any req bit is high, the FSM SHALL pick a winner and go to SWITCH.
REQ-014 Winner selection SHALL be round-robin: search req from last_owner+1 upward, wrapping at MASTER_QTY-1 to 0; the first high bit wins.
REQ-015 SWITCH lasts exactly 1 cycle: msel=winner, gnt=0 (turnaround so the mux settles before the grant); it SHALL go to OWNED unconditionally.
REQ-016 OWNED: gnt[owner]=1, msel=owner, last_owner<=owner, hold_cnt increments each cycle starting from 0 in the first OWNED cycle.
REQ-017 OWNED release: when req[owner]=0 and busy=0, go to SWITCH if any other req bit is high (new round-robin winner), else to IDLE.
REQ-018 If req[owner]=0 while busy=1, the FSM SHALL stay in OWNED with gnt held until busy=0.
REQ-019 Forced release (MAX_HOLD!=0): when hold_cnt >= MAX_HOLD, busy=0 and another master requests, the FSM SHALL go to SWITCH even if req[owner]=1.
REQ-020 After a forced release, the round-robin search starts at owner+1, so the preempted master is served last among the current requesters.
REQ-021 Request-to-grant latency from IDLE SHALL be 2 cycles: req sampled high at edge N gives SWITCH after N and gnt high after N+1.
REQ-022 Handover latency SHALL be 1 dead cycle: the old gnt falls and the new gnt rises exactly 2 edges after the releasing edge.
REQ-023 Simultaneous requests in IDLE SHALL resolve by the round-robin pointer only; there is no fixed priority.
REQ-024 req bits of non-owners that drop before selection SHALL be ignored; glitch-free one-hot gnt is required at all times.
REQ-025 With MASTER_QTY=1, msel SHALL be constant 0 and the FSM SHALL still perform the IDLE/SWITCH/OWNED handshake.
REQ-026 msel SHALL never exceed MASTER_QTY-1.

Reset
REQ-027 While rst=1, asynchronously: state=IDLE, gnt=0, gnt_valid=0, msel=0, hold_cnt=0, last_owner=MASTER_QTY-1 (first search starts at master 0).
REQ-028 Reset asserted mid-tenure or mid-SWITCH SHALL drop gnt in the same cycle regardless of busy; after release the FSM resumes from IDLE on the next edge.

Verification
REQ-029 MASTER_QTY=2: reset, then req=2'b11 at one edge -> SWITCH with msel=0 after the next edge, gnt=2'b01 one edge later.
REQ-030 Owner 0 drops req with busy=1 for 3 cycles, master 1 waiting -> gnt=2'b01 held for 3 cycles, then 1 dead cycle, then gnt=2'b10 with msel=1.
REQ-031 MASTER_QTY=4, req=4'b1111 held, each owner releases after 5 cycles -> grant order 0,1,2,3,0; each gap is exactly 1 zero-gnt cycle.
REQ-032 MAX_HOLD=8, master 0 holds req, master 1 requests at cycle 2 -> gnt[0] drops when hold_cnt=8 and busy=0; gnt[1] rises 2 edges later.
REQ-033 rst pulsed while gnt=2'b10 and busy=1 -> gnt=0 and msel=0 immediately; after release with req=2'b10, msel=1 and gnt=2'b10 after 2 edges.
REQ-034 Assertion checks run in every test: gnt is one-hot-or-zero, gnt_valid equals |gnt, msel < MASTER_QTY, and no gnt change while busy=1 except on reset.
